// File: rtl/pong_pkg.sv
// Shared types, point codes and the tennis scoring rule for the pong match controller.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    RALLY = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [2:0] PT_0    = 3'd0;
  localparam logic [2:0] PT_15   = 3'd1;
  localparam logic [2:0] PT_30   = 3'd2;
  localparam logic [2:0] PT_40   = 3'd3;
  localparam logic [2:0] PT_ADV  = 3'd4;
  localparam logic [2:0] PT_GAME = 3'd5;

  // Debug view of the controller: FSM state plus each player's swing readiness.
  typedef struct packed {
    state_e state;
    logic   p1_ready;
    logic   p2_ready;
  } dbg_t;

  // Returns the updated {winner, loser} point codes after the winner takes a point.
  function automatic logic [5:0] next_pts(input logic [2:0] w, input logic [2:0] l);
    logic [5:0] r;
    r = {w, l};
    if (w < PT_40) begin
      r = {w + 3'd1, l};
    end else if (w == PT_40) begin
      if (l < PT_40)       r = {PT_GAME, l};
      else if (l == PT_40) r = {PT_ADV, l};
      else                 r = {PT_40, PT_40};   // loser loses advantage: deuce
    end else if (w == PT_ADV) begin
      r = {PT_GAME, l};
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_swing.sv
// One player's swing front end: button edge detect, zone mask / power, and the
// post-swing lockout counter. A swing is consumed only when the player is ready
// and the cycle is not pre-empted by an out-of-court event.
module pong_swing
  import pong_pkg::*;
#(
  parameter  int ZONE_W    = 5,
  parameter  int MAX_POWER = 3,
  parameter  int COOLDOWN  = 50000000,
  localparam int PW        = $clog2(MAX_POWER + 1),
  localparam int CW        = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_i,
  input  logic [ZONE_W-1:0] zone_sw_i,
  input  logic [ZONE_W-1:0] zone_pos_i,
  input  logic              block_i,
  output logic              swing_valid_o,
  output logic [PW-1:0]     power_o,
  output logic              zone_hit_o,
  output logic              ready_o
);

  logic              btn_q;
  logic              ready_q, ready_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ZONE_W-1:0] mask;

  // Mark set switches from the low end of the zone until MAX_POWER are taken.
  always_comb begin : mask_calc
    int marked;
    mask   = '0;
    marked = 0;
    for (int i = 0; i < ZONE_W; i++) begin
      if (zone_sw_i[i] && (marked < MAX_POWER)) begin
        mask[i] = 1'b1;
        marked++;
      end
    end
    power_o = PW'(marked);
  end

  assign zone_hit_o    = |(zone_pos_i & mask);
  assign swing_valid_o = btn_i & ~btn_q & ready_q & ~block_i;
  assign ready_o       = ready_q;

  // Lockout: load on a swing, count down, become ready the cycle after zero.
  always_comb begin
    ready_d = ready_q;
    cnt_d   = cnt_q;
    if (swing_valid_o) begin
      ready_d = 1'b0;
      cnt_d   = CW'(COOLDOWN - 1);
    end else if (!ready_q) begin
      if (cnt_q == '0) ready_d = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // Button history and lockout state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      btn_q   <= btn_i;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match controller for the LED-court pong game: serve/return arbitration,
// ball speed/direction/halt, tennis scoring and match restart.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter  int COURT_W   = 10,
  parameter  int ZONE_W    = 5,
  parameter  int MAX_POWER = 3,
  parameter  int COOLDOWN  = 50000000,
  localparam int PW        = $clog2(MAX_POWER + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COURT_W-1:0] sw,
  input  logic               p1_btn,
  input  logic               p2_btn,
  input  logic               ctrl,
  input  logic [COURT_W-1:0] position,
  input  logic               outside,
  input  logic               winner,
  output logic [PW-1:0]      speed,
  output logic               direction,
  output logic               halt,
  output logic               rstball,
  output logic               server,
  output logic [2:0]         p1_pts,
  output logic [2:0]         p2_pts,
  output logic               game_over,
  output dbg_t               dbg_o
);

  localparam int P2_BASE = COURT_W - ZONE_W;

  state_e          state_q;
  logic [PW-1:0]   speed_q;
  logic            dir_q, halt_q, rstball_q, server_q, game_over_q, ctrl_q;
  logic [2:0]      p1_pts_q, p2_pts_q;
  logic [5:0]      pts_d;

  logic            p1_sv, p2_sv, p1_zh, p2_zh, p1_rdy, p2_rdy;
  logic [PW-1:0]   p1_pow, p2_pow;
  logic            block, ctrl_edge, p1_hit, p2_hit;

  // An out-of-court event during a rally swallows any swing in the same cycle.
  assign block     = outside & (state_q == RALLY);
  assign ctrl_edge = ctrl & ~ctrl_q;

  pong_swing #(.ZONE_W(ZONE_W), .MAX_POWER(MAX_POWER), .COOLDOWN(COOLDOWN)) u_p1 (
    .clk(clk), .rst_n(rst_n), .btn_i(p1_btn),
    .zone_sw_i(sw[ZONE_W-1:0]), .zone_pos_i(position[ZONE_W-1:0]), .block_i(block),
    .swing_valid_o(p1_sv), .power_o(p1_pow), .zone_hit_o(p1_zh), .ready_o(p1_rdy)
  );

  pong_swing #(.ZONE_W(ZONE_W), .MAX_POWER(MAX_POWER), .COOLDOWN(COOLDOWN)) u_p2 (
    .clk(clk), .rst_n(rst_n), .btn_i(p2_btn),
    .zone_sw_i(sw[P2_BASE +: ZONE_W]), .zone_pos_i(position[P2_BASE +: ZONE_W]), .block_i(block),
    .swing_valid_o(p2_sv), .power_o(p2_pow), .zone_hit_o(p2_zh), .ready_o(p2_rdy)
  );

  // In SERVE only the server may hit; in a rally only the player the ball approaches.
  assign p1_hit = p1_sv & p1_zh & ((state_q == SERVE) ? ~server_q : dir_q);
  assign p2_hit = p2_sv & p2_zh & ((state_q == SERVE) ?  server_q : ~dir_q);

  // Score after the current point, ordered {winner, loser}.
  always_comb begin
    pts_d = winner ? next_pts(p1_pts_q, p2_pts_q) : next_pts(p2_pts_q, p1_pts_q);
  end

  // Match FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      speed_q     <= '0;
      dir_q       <= 1'b0;
      halt_q      <= 1'b1;
      rstball_q   <= 1'b0;
      server_q    <= 1'b0;
      p1_pts_q    <= PT_0;
      p2_pts_q    <= PT_0;
      game_over_q <= 1'b0;
      ctrl_q      <= 1'b0;
    end else begin
      ctrl_q    <= ctrl;
      rstball_q <= 1'b0;
      case (state_q)
        SERVE: begin
          halt_q <= 1'b1;
          if (p1_hit) begin
            speed_q <= p1_pow;
            dir_q   <= 1'b0;
            halt_q  <= 1'b0;
            state_q <= RALLY;
          end else if (p2_hit) begin
            speed_q <= p2_pow;
            dir_q   <= 1'b1;
            halt_q  <= 1'b0;
            state_q <= RALLY;
          end
        end
        RALLY: begin
          if (outside) begin
            // Point outputs are registered on entry so they are visible during POINT.
            halt_q    <= 1'b1;
            rstball_q <= 1'b1;
            server_q  <= ~winner;
            dir_q     <= ~winner;
            if (winner) {p1_pts_q, p2_pts_q} <= pts_d;
            else        {p2_pts_q, p1_pts_q} <= pts_d;
            state_q   <= POINT;
          end else if (p1_hit) begin
            speed_q <= p1_pow;
            dir_q   <= 1'b0;
          end else if (p2_hit) begin
            speed_q <= p2_pow;
            dir_q   <= 1'b1;
          end
        end
        POINT: begin
          if ((p1_pts_q == PT_GAME) || (p2_pts_q == PT_GAME)) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else begin
            state_q <= SERVE;
          end
        end
        OVER: begin
          if (ctrl_edge) begin
            p1_pts_q    <= PT_0;
            p2_pts_q    <= PT_0;
            server_q    <= 1'b0;
            dir_q       <= 1'b0;
            speed_q     <= '0;
            rstball_q   <= 1'b1;
            game_over_q <= 1'b0;
            state_q     <= SERVE;
          end
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign speed     = speed_q;
  assign direction = dir_q;
  assign halt      = halt_q;
  assign rstball   = rstball_q;
  assign server    = server_q;
  assign p1_pts    = p1_pts_q;
  assign p2_pts    = p2_pts_q;
  assign game_over = game_over_q;
  assign dbg_o     = '{state: state_q, p1_ready: p1_rdy, p2_ready: p2_rdy};

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Parametrised match controller for the LED-court pong/tennis game. It sits between the switch/button inputs and the ball-mover block. It arbitrates serves and returns from two players, computes return power from each player's zone switches, and drives ball speed, direction and halt. It also keeps full tennis scoring (0/15/30/40/deuce/advantage/game) through a proper state machine, and restarts the match on request.

Parameters:
COURT_W, 10, number of ball positions (LEDs); P1 owns indices 0..ZONE_W-1, P2 owns COURT_W-ZONE_W..COURT_W-1
ZONE_W, 5, width of each player's hit zone; must satisfy 2*ZONE_W <= COURT_W
MAX_POWER, 3, maximum speed level and maximum number of active zone switches counted
COOLDOWN, 50000000, clock cycles a player is locked out after any swing
PW, $clog2(MAX_POWER+1), speed width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sw  in  COURT_W  zone-select switches; each player reads only their own zone
p1_btn  in  1  P1 swing button, already debounced and synchronous to clk
p2_btn  in  1  P2 swing button, already debounced and synchronous to clk
ctrl  in  1  new-match request, level input, rising-edge detected
position  in  COURT_W  one-hot ball position from the ball mover
outside  in  1  ball left the court (single-cycle pulse)
winner  in  1  valid with outside; 1 = P1 wins the point, 0 = P2 wins
speed  out  PW  ball speed level of the last successful hit
direction  out  1  0 = ball travels toward P2 (high index), 1 = toward P1
halt  out  1  1 = ball frozen
rstball  out  1  one-cycle pulse: ball mover repositions ball at the server's end
server  out  1  0 = P1 serves, 1 = P2 serves
p1_pts  out  3  P1 point code: 0=0, 1=15, 2=30, 3=40, 4=ADV, 5=GAME
p2_pts  out  3  P2 point code, same encoding
game_over  out  1  high while in OVER

Behaviour:
- Reset (async, rst_n=0) sets the following:
  - speed=0, direction=0, halt=1, rstball=0, server=0, p1_pts=p2_pts=0, game_over=0.
  - Both players ready, cooldown counters 0, FSM in SERVE.
- Buttons and ctrl are rising-edge detected using one registered copy each. An edge seen at clock n takes effect on outputs at edge n+1.
- Swing evaluation for player X, performed only when X is ready:
  - Zone mask: scan X's zone from its lowest index upward. Mark set switches until MAX_POWER are marked.
  - Power: number of marked switches, range 0..MAX_POWER.
  - Hit: (position AND mask) != 0 AND the ball is approaching X (P1 requires direction=1, P2 requires direction=0).
  - In SERVE, the approach check is replaced by a check that X is the server.
  - Every swing, hit or miss, clears X's ready and loads the cooldown counter with COOLDOWN-1. The counter decrements each cycle; ready returns to 1 the cycle after it reaches 0.
  - A swing edge while not ready is ignored and does not reload the counter.
- A hit does the following:
  - speed = power.
  - direction toggles: it is forced to 0 for a P1 hit and to 1 for a P2 hit.
  - halt = 0.
  - In SERVE, the FSM moves to RALLY.
  - A power-0 hit still hits and sets speed=0.
- FSM:
  - SERVE: halt=1. A server hit goes to RALLY. Swings by the non-server count as misses.
  - RALLY: halt=0. Hits return the ball. outside goes to POINT.
  - POINT: lasts one cycle and does the following:
    - Sets halt=1 and updates the score.
    - server = loser of the point ? ... the point winner.
    - direction = (winner==1) ? 0 : 1.
    - Pulses rstball for this cycle.
    - Goes to OVER if a score reached 5 (GAME), otherwise to SERVE.
  - OVER: halt=1, game_over=1. A rising edge on ctrl does the following:
    - Clears both scores, sets server=0, direction=0, speed=0.
    - Pulses rstball for one cycle.
    - Goes to SERVE.
- Scoring, with W = point winner and L = loser:
  - W<3: W+1.
  - W=3 and L<3: W=5.
  - W=3 and L=3: W=4.
  - W=3 and L=4: L=3 (back to deuce).
  - W=4: W=5.
  - Codes 6 and 7 never occur.
- Simultaneous events:
  - outside plus a swing in the same cycle: outside wins and the swing is ignored entirely, including its cooldown.
  - Both players swing in the same cycle: each is evaluated independently. Only the player the ball is approaching can hit; the other is a miss.
- outside in SERVE or OVER is ignored. ctrl outside OVER is ignored.
- Reset asserted mid-rally or mid-cooldown returns every output to its reset value immediately.

Decomposition:
- Package pong_pkg holds:
  - The FSM state enum: SERVE, RALLY, POINT, OVER.
  - Point-code localparams: PT_0, PT_15, PT_30, PT_40, PT_ADV, PT_GAME.
  - A pure function next_pts(w,l) returning the updated {w,l} pair.
- Sub-module pong_swing, instantiated once per player, parametrised by zone base index. It contains:
  - The edge detector.
  - Mask/power computation.
  - The cooldown counter.
  - Outputs: swing_valid, power, zone_hit.

Test Plan:
- Reset with COOLDOWN=4, P1 sw[0..4]=1, position[2]=1; P1 btn edge -> next cycle halt=0, direction=0, speed=3 (saturated); second P1 edge within 4 cycles is ignored.
- RALLY, ball at position[7] with direction=0, P2 sw[7]=1 only; P2 edge -> direction=1, speed=1. A P1 edge in the same cycle has no effect on direction.
- Score P1=3, P2=3; outside with winner=1 -> p1_pts=4. Then outside with winner=0 -> p1_pts=3, p2_pts=3.
- Score P1=4, P2=3; outside with winner=1 -> p1_pts=5, game_over=1, rstball pulses once. ctrl edge -> scores 0, server=0, rstball pulses, SERVE.
- In SERVE with server=1, P1 edge while ball in P1 zone -> halt stays 1 and P1 cooldown starts. outside and P2 swing in the same cycle in RALLY -> POINT taken, P2 ready unchanged.
- Assert rst_n low mid-RALLY -> halt=1, speed=0, pts=0 asynchronously, before the next clk edge.
